// File: rtl/boton_pulsos.sv
// Navigation pushbutton front end: synchronise, debounce and turn the left/right
// buttons into single-cycle step pulses, with optional auto-repeat while held.
module boton_pulsos #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_izq_raw,
    input  logic btn_der_raw,
    output logic boton_izquierda,
    output logic boton_derecha,
    output logic izq_estable,
    output logic der_estable
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       deb;
    logic [1:0]       deb_nx;
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_req;
    logic [1:0]       pulse_nx;
    logic             both_held;
    logic [CNT_W-1:0] db_cnt   [2];
    logic [CNT_W-1:0] db_cnt_nx[2];
    logic [CNT_W-1:0] hold_cnt [2];
    logic [CNT_W-1:0] hold_nx  [2];
    state_t           state    [2];
    state_t           state_nx [2];

    assign raw = {btn_der_raw, btn_izq_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            deb     <= '0;
            pulse_q <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt[b]   <= '0;
                hold_cnt[b] <= '0;
                state[b]    <= IDLE;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            deb     <= deb_nx;
            pulse_q <= pulse_nx;
            for (int b = 0; b < 2; b++) begin
                db_cnt[b]   <= db_cnt_nx[b];
                hold_cnt[b] <= hold_nx[b];
                state[b]    <= state_nx[b];
            end
        end
    end

    always_comb begin
        both_held = deb[0] & deb[1];
        pulse_req = '0;
        deb_nx    = deb;
        for (int b = 0; b < 2; b++) begin
            db_cnt_nx[b] = '0;
            hold_nx[b]   = hold_cnt[b];
            state_nx[b]  = state[b];

            if (s2[b] != deb[b]) begin
                if (db_cnt[b] == DB_LAST) begin
                    deb_nx[b] = ~deb[b];
                end else begin
                    db_cnt_nx[b] = db_cnt[b] + 1'b1;
                end
            end

            // While both levels are high the hold counter sits at zero, so the
            // surviving button restarts a full repeat delay once the other lets go.
            case (state[b])
                IDLE: begin
                    if (deb[b]) begin
                        state_nx[b]  = PRESSED;
                        hold_nx[b]   = '0;
                        pulse_req[b] = ~both_held;
                    end
                end
                PRESSED: begin
                    if (!deb[b]) begin
                        state_nx[b] = IDLE;
                        hold_nx[b]  = '0;
                    end else if (both_held) begin
                        hold_nx[b] = '0;
                    end else if (REPEAT_DELAY != 0) begin
                        if (hold_cnt[b] == RD_LAST) begin
                            state_nx[b]  = REPEAT;
                            hold_nx[b]   = '0;
                            pulse_req[b] = 1'b1;
                        end else begin
                            hold_nx[b] = hold_cnt[b] + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!deb[b]) begin
                        state_nx[b] = IDLE;
                        hold_nx[b]  = '0;
                    end else if (both_held) begin
                        state_nx[b] = PRESSED;
                        hold_nx[b]  = '0;
                    end else if (hold_cnt[b] == RP_LAST) begin
                        hold_nx[b]   = '0;
                        pulse_req[b] = 1'b1;
                    end else begin
                        hold_nx[b] = hold_cnt[b] + 1'b1;
                    end
                end
                default: begin
                    state_nx[b] = IDLE;
                    hold_nx[b]  = '0;
                end
            endcase
        end
        pulse_nx = (pulse_req == 2'b11) ? 2'b00 : pulse_req;
    end

    assign boton_izquierda = pulse_q[0];
    assign boton_derecha   = pulse_q[1];
    assign izq_estable     = deb[0];
    assign der_estable     = deb[1];

endmodule

// File: tb/tb_boton_pulsos.sv
// Directed bench for boton_pulsos with small debounce/repeat parameters;
// pulse edge numbers are recorded and scored against hand-computed lists.
module tb_boton_pulsos;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk;
    logic rst_n;
    logic izq;
    logic der;
    logic boton_izquierda;
    logic boton_derecha;
    logic izq_estable;
    logic der_estable;

    int vectors;
    int errors;
    int cyc;
    int n;
    logic both_seen;

    logic [31:0] izq_obs[$];
    logic [31:0] der_obs[$];
    logic [31:0] izq_exp_q[$];
    logic [31:0] der_exp_q[$];

    boton_pulsos #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_izq_raw    (izq),
        .btn_der_raw    (der),
        .boton_izquierda(boton_izquierda),
        .boton_derecha  (boton_derecha),
        .izq_estable    (izq_estable),
        .der_estable    (der_estable)
    );

    // Clock and edge counter: cyc equals the number of rising edges seen.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor on the falling edge: logs the rising edge each pulse started on.
    initial both_seen = 1'b0;
    always @(negedge clk) begin
        if (boton_izquierda) izq_obs.push_back(cyc);
        if (boton_derecha)   der_obs.push_back(cyc);
        if (boton_izquierda && boton_derecha) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int count);
        repeat (count) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic score(input string tag);
        check({tag, "_izq_count"}, izq_obs.size(), izq_exp_q.size());
        check({tag, "_der_count"}, der_obs.size(), der_exp_q.size());
        for (int i = 0; i < izq_exp_q.size() && i < izq_obs.size(); i++)
            check({tag, "_izq_edge"}, izq_obs[i], izq_exp_q[i]);
        for (int i = 0; i < der_exp_q.size() && i < der_obs.size(); i++)
            check({tag, "_der_edge"}, der_obs[i], der_exp_q[i]);
        izq_obs.delete();
        der_obs.delete();
        izq_exp_q.delete();
        der_exp_q.delete();
    endtask

    function automatic logic [3:0] outs();
        return {boton_izquierda, boton_derecha, izq_estable, der_estable};
    endfunction

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        izq     = 1'b0;
        der     = 1'b0;

        // Reset state
        #3;
        check("reset_outputs", outs(), 4'b0000);
        step(3);
        rst_n = 1'b1;
        step(1);
        check("first_edge_after_reset", outs(), 4'b0000);
        step(4);

        // 1: clean right press; raw sampled at n+1, level at n+6, pulse at n+7
        n = cyc;
        der = 1'b1;
        step(5);
        check("t1_der_estable_low", der_estable, 1'b0);
        step(1);
        check("t1_der_estable_high", der_estable, 1'b1);
        step(4);
        der = 1'b0;
        step(20);
        check("t1_der_estable_released", der_estable, 1'b0);
        der_exp_q.push_back(n + 7);
        score("t1");

        // 2: bouncy left press and bouncy release
        n = cyc;
        izq = 1'b1; step(1);
        izq = 1'b0; step(1);
        izq = 1'b1; step(1);
        izq = 1'b0; step(1);
        izq = 1'b1;
        step(6);
        check("t2_izq_estable_high", izq_estable, 1'b1);
        step(4);
        izq = 1'b0; step(1);
        izq = 1'b1; step(1);
        izq = 1'b0; step(1);
        izq = 1'b1; step(1);
        izq = 1'b0;
        step(15);
        check("t2_izq_estable_released", izq_estable, 1'b0);
        izq_exp_q.push_back(n + 11);
        score("t2");

        // 3: auto-repeat, press pulse P = n+7, then P+20, then every 8
        n = cyc;
        der = 1'b1;
        step(60);
        der = 1'b0;
        step(15);
        der_exp_q.push_back(n + 7);
        der_exp_q.push_back(n + 27);
        der_exp_q.push_back(n + 35);
        der_exp_q.push_back(n + 43);
        der_exp_q.push_back(n + 51);
        der_exp_q.push_back(n + 59);
        score("t3");

        // 4: both pressed together; left level falls at n+46, right repeats from n+66
        n = cyc;
        izq = 1'b1;
        der = 1'b1;
        step(40);
        check("t4_both_estable", {izq_estable, der_estable}, 2'b11);
        izq = 1'b0;
        step(43);
        der = 1'b0;
        step(15);
        der_exp_q.push_back(n + 66);
        der_exp_q.push_back(n + 74);
        der_exp_q.push_back(n + 82);
        score("t4");

        // 5: staggered, right accepted first, left joins two cycles later
        n = cyc;
        der = 1'b1;
        step(2);
        izq = 1'b1;
        step(13);
        izq = 1'b0;
        der = 1'b0;
        step(15);
        der_exp_q.push_back(n + 7);
        score("t5");

        // 6: reset during a repeat pulse, button still held
        n = cyc;
        der = 1'b1;
        step(27);
        check("t6_repeat_pulse_high", boton_derecha, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_outputs_in_reset", outs(), 4'b0000);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("t6_first_edge_after_release", outs(), 4'b0000);
        step(11);
        der = 1'b0;
        step(15);
        der_exp_q.push_back(n + 7);
        der_exp_q.push_back(n + 35);
        score("t6");

        check("never_both_pulses", both_seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
